// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: dual-channel servo pulse generator, one pulse per channel
// per fixed-period frame, widths sampled only at frame start.
// Optional build macro: SERVO_PWM_CLAMP_EN clamps latched widths to
// [PW_MIN_US, PW_MAX_US]; when undefined, raw widths are latched.
module servo_pwm_gen #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned PERIOD_US    = 20000,
    parameter int unsigned PW_MIN_US    = 500,
    parameter int unsigned PW_MAX_US    = 2500,
    parameter int unsigned X_DEFAULT_US = 1500,
    parameter int unsigned Y_DEFAULT_US = 1200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] x_pw_us,
    input  logic [10:0] y_pw_us,
    output logic        pwm_x,
    output logic        pwm_y,
    output logic        frame_start,
    output logic        running
);

    localparam int unsigned PW_W  = 11;
    localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned US_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int unsigned CMP_W = (US_W > PW_W) ? US_W : PW_W;

    // Elaboration-time parameter sanity checks
    if ((CLK_FREQ_HZ % 1_000_000) != 0 || DIV == 0) begin : g_bad_clk
        $error("CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
    end
    if (PW_MIN_US > PW_MAX_US || PW_MAX_US >= PERIOD_US) begin : g_bad_clamp
        $error("clamp bounds must satisfy PW_MIN_US <= PW_MAX_US < PERIOD_US");
    end
`ifndef SERVO_PWM_CLAMP_EN
    if (PERIOD_US <= 2047) begin : g_bad_period
        $error("PERIOD_US must exceed the largest raw width (2047)");
    end
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [PW_W-1:0]   x_lat_q, x_lat_d;
    logic [PW_W-1:0]   y_lat_q, y_lat_d;
    logic              pwm_x_q, pwm_x_d;
    logic              pwm_y_q, pwm_y_d;
    logic              fs_q, fs_d;
    logic              run_q, run_d;
    logic              us_tick;
    logic              frame_end;
    logic              start_frame;

    // Width conditioning applied at the latch point
    function automatic logic [PW_W-1:0] shape_width(input logic [PW_W-1:0] w);
`ifdef SERVO_PWM_CLAMP_EN
        if (w < PW_W'(PW_MIN_US)) begin
            return PW_W'(PW_MIN_US);
        end else if (w > PW_W'(PW_MAX_US)) begin
            return PW_W'(PW_MAX_US);
        end else begin
            return w;
        end
`else
        return w;
`endif
    endfunction

    assign us_tick   = (pre_q == PRE_W'(DIV - 1));
    assign frame_end = us_tick && (us_q == US_W'(PERIOD_US - 1));

    // Next-state, counter advance, width latching and output decode
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        us_d        = us_q;
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        fs_d        = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                us_d  = '0;
                if (en) begin
                    start_frame = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (us_tick) begin
                    pre_d = '0;
                    us_d  = frame_end ? '0 : us_q + 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                // A frame in progress always completes; en only decides what follows
                if (frame_end) begin
                    if (en) begin
                        start_frame = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = en ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
                us_d    = '0;
            end
        endcase

        if (start_frame) begin
            pre_d   = '0;
            us_d    = '0;
            x_lat_d = shape_width(x_pw_us);
            y_lat_d = shape_width(y_pw_us);
            fs_d    = 1'b1;
        end

        run_d   = (state_d != S_IDLE);
        pwm_x_d = run_d && (CMP_W'(us_d) < CMP_W'(x_lat_d));
        pwm_y_d = run_d && (CMP_W'(us_d) < CMP_W'(y_lat_d));
    end

    // State, counters, latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            us_q    <= '0;
            x_lat_q <= PW_W'(X_DEFAULT_US);
            y_lat_q <= PW_W'(Y_DEFAULT_US);
            pwm_x_q <= 1'b0;
            pwm_y_q <= 1'b0;
            fs_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            us_q    <= us_d;
            x_lat_q <= x_lat_d;
            y_lat_q <= y_lat_d;
            pwm_x_q <= pwm_x_d;
            pwm_y_q <= pwm_y_d;
            fs_q    <= fs_d;
            run_q   <= run_d;
        end
    end

    assign pwm_x       = pwm_x_q;
    assign pwm_y       = pwm_y_q;
    assign frame_start = fs_q;
    assign running     = run_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen (DIV=2, PERIOD_US=2600, frame = 5200 cycles).
// Define SERVO_PWM_CLAMP_EN for both RTL and bench to check the clamped build.
module tb_servo_pwm_gen;

    localparam int unsigned CLK_HZ = 2_000_000;
    localparam int unsigned PER    = 2600;
    localparam int          DIV    = 2;
    localparam int          FRAME  = PER * DIV;
`ifdef SERVO_PWM_CLAMP_EN
    localparam int          EXP_X0 = 500 * DIV;
    localparam int          EXP_YM = 2500 * DIV;
`else
    localparam int          EXP_X0 = 0;
    localparam int          EXP_YM = 2047 * DIV;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [10:0] x_pw  = 11'd1500;
    logic [10:0] y_pw  = 11'd1200;
    logic        pwm_x, pwm_y, frame_start, running;

    servo_pwm_gen #(
        .CLK_FREQ_HZ (CLK_HZ),
        .PERIOD_US   (PER)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .x_pw_us     (x_pw),
        .y_pw_us     (y_pw),
        .pwm_x       (pwm_x),
        .pwm_y       (pwm_y),
        .frame_start (frame_start),
        .running     (running)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, fs_cnt = 0, fs_cyc = 0, gap = 0;
    int hx = 0, hy = 0, last_hx = 0, last_hy = 0;
    int fall_cyc = 0, run_low = 0, bad_rise = 0, idle_pwm = 0;
    logic px_prev = 1'b0, py_prev = 1'b0, run_prev = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Frame monitor: samples 1 time unit after every rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (frame_start) begin
            gap     = cyc - fs_cyc;
            fs_cyc  = cyc;
            last_hx = hx;
            last_hy = hy;
            hx      = pwm_x ? 1 : 0;
            hy      = pwm_y ? 1 : 0;
            fs_cnt++;
        end else begin
            hx += pwm_x ? 1 : 0;
            hy += pwm_y ? 1 : 0;
            if ((pwm_x && !px_prev) || (pwm_y && !py_prev)) bad_rise++;
        end
        if (!running && run_prev) fall_cyc = cyc;
        if (!running) run_low++;
        if (!running && (pwm_x || pwm_y)) idle_pwm++;
        px_prev  = pwm_x;
        py_prev  = pwm_y;
        run_prev = running;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_fs(input int target, input string tag);
        for (int i = 0; i < 3 * FRAME && fs_cnt < target; i++) step(1);
        check_eq(tag, fs_cnt, target);
    endtask

    int t;

    initial begin
        // Reset state
        step(3);
        check_eq("rst_pwm_x", int'(pwm_x), 0);
        check_eq("rst_pwm_y", int'(pwm_y), 0);
        check_eq("rst_frame_start", int'(frame_start), 0);
        check_eq("rst_running", int'(running), 0);
        check_eq("rst_x_lat", int'(dut.x_lat_q), 1500);
        check_eq("rst_y_lat", int'(dut.y_lat_q), 1200);

        @(negedge clk) rst_n = 1'b1;
        step(2);
        check_eq("idle_running", int'(running), 0);
        check_eq("idle_no_fs", fs_cnt, 0);

        // Start: the edge that sees en=1 begins a frame
        en = 1'b1;
        step(1);
        check_eq("start_fs", int'(frame_start), 1);
        check_eq("start_pwm_x", int'(pwm_x), 1);
        check_eq("start_pwm_y", int'(pwm_y), 1);
        check_eq("start_running", int'(running), 1);
        step(1);
        check_eq("fs_one_cycle", int'(frame_start), 0);

        wait_fs(2, "wait_fs2");
        check_eq("gap_f1", gap, FRAME);
        check_eq("hx_1500", last_hx, 3000);
        check_eq("hy_1200", last_hy, 2400);

        // Mid-frame width change only affects the next frame
        step(1000);
        x_pw = 11'd1000;
        wait_fs(3, "wait_fs3");
        check_eq("hx_unchanged", last_hx, 3000);
        wait_fs(4, "wait_fs4");
        check_eq("hx_1000", last_hx, 2000);
        check_eq("gap_f3", gap, FRAME);

        // Short en glitch inside a frame
        step(1500);
        run_low = 0;
        en = 1'b0;
        step(100);
        en = 1'b1;
        wait_fs(5, "wait_fs5");
        check_eq("glitch_gap", gap, FRAME);
        check_eq("glitch_run_low", run_low, 0);

        // Extreme widths
        x_pw = 11'd0;
        y_pw = 11'd2047;
        wait_fs(6, "wait_fs6");
        wait_fs(7, "wait_fs7");
        check_eq("hx_zero", last_hx, EXP_X0);
        check_eq("hy_2047", last_hy, EXP_YM);

        // Stop: current frame completes, then idle
        step(3500);
        en = 1'b0;
        for (int i = 0; i < 2 * FRAME && running; i++) step(1);
        check_eq("stop_running", int'(running), 0);
        check_eq("stop_len", fall_cyc - fs_cyc, FRAME);
        check_eq("stop_hx", hx, EXP_X0);
        check_eq("stop_hy", hy, EXP_YM);
        t = fs_cnt;
        step(6000);
        check_eq("stop_no_fs", fs_cnt, t);
        check_eq("stop_pwm_x", int'(pwm_x), 0);
        check_eq("stop_pwm_y", int'(pwm_y), 0);

        // Asynchronous reset mid-pulse restores defaults
        x_pw = 11'd1000;
        y_pw = 11'd800;
        en   = 1'b1;
        wait_fs(t + 1, "wait_restart");
        step(200);
        check_eq("pre_rst_pwm_x", int'(pwm_x), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_pwm_x", int'(pwm_x), 0);
        check_eq("arst_pwm_y", int'(pwm_y), 0);
        check_eq("arst_running", int'(running), 0);
        check_eq("arst_x_lat", int'(dut.x_lat_q), 1500);
        check_eq("arst_y_lat", int'(dut.y_lat_q), 1200);
        x_pw = 11'd1500;
        y_pw = 11'd1200;
        step(3);
        @(negedge clk) rst_n = 1'b1;
        t = fs_cnt;
        wait_fs(t + 1, "wait_post_rst1");
        wait_fs(t + 2, "wait_post_rst2");
        check_eq("post_rst_hx", last_hx, 3000);
        check_eq("post_rst_hy", last_hy, 2400);
        check_eq("post_rst_gap", gap, FRAME);

        check_eq("rise_without_fs", bad_rise, 0);
        check_eq("pwm_while_idle", idle_pwm, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
